// File: rtl/memory_bus_responder_pkg.sv
// Address map, TX_STATUS bit layout and the address decoder shared by the
// memory bus responder and anything that talks to it.
package memory_map;

  // Byte addresses of the peripheral registers
  localparam logic [31:0] GPIO_ADDR      = 32'h1000_0000;
  localparam logic [31:0] CYCLE_LO_ADDR  = 32'h1000_0004;
  localparam logic [31:0] CYCLE_HI_ADDR  = 32'h1000_0008;
  localparam logic [31:0] TX_DATA_ADDR   = 32'h1000_000C;
  localparam logic [31:0] TX_STATUS_ADDR = 32'h1000_0010;

  // Word addresses used by the decoder (byte offset bits dropped)
  localparam logic [29:0] GPIO_WADDR      = GPIO_ADDR[31:2];
  localparam logic [29:0] CYCLE_LO_WADDR  = CYCLE_LO_ADDR[31:2];
  localparam logic [29:0] CYCLE_HI_WADDR  = CYCLE_HI_ADDR[31:2];
  localparam logic [29:0] TX_DATA_WADDR   = TX_DATA_ADDR[31:2];
  localparam logic [29:0] TX_STATUS_WADDR = TX_STATUS_ADDR[31:2];

  // TX_STATUS bit positions
  localparam int STAT_FULL_BIT     = 0;
  localparam int STAT_EMPTY_BIT    = 1;
  localparam int STAT_COUNT_LSB    = 2;
  localparam int STAT_COUNT_MSB    = 4;
  localparam int STAT_OVERFLOW_BIT = 5;

  typedef enum logic [2:0] {
    REGION_RAM       = 3'd0,
    REGION_GPIO      = 3'd1,
    REGION_CYCLE_LO  = 3'd2,
    REGION_CYCLE_HI  = 3'd3,
    REGION_TX_DATA   = 3'd4,
    REGION_TX_STATUS = 3'd5,
    REGION_UNMAPPED  = 3'd6
  } region_e;

  // RAM hit is computed by the caller because it depends on the RAM depth.
  function automatic region_e decode_region(input logic [29:0] word_addr,
                                            input logic        ram_hit);
    region_e region;
    if (ram_hit) begin
      region = REGION_RAM;
    end else begin
      case (word_addr)
        GPIO_WADDR:      region = REGION_GPIO;
        CYCLE_LO_WADDR:  region = REGION_CYCLE_LO;
        CYCLE_HI_WADDR:  region = REGION_CYCLE_HI;
        TX_DATA_WADDR:   region = REGION_TX_DATA;
        TX_STATUS_WADDR: region = REGION_TX_STATUS;
        default:         region = REGION_UNMAPPED;
      endcase
    end
    return region;
  endfunction

endpackage

// File: rtl/memory_bus_responder_tx_fifo.sv
// Small register-based byte FIFO for the TX path. A push into a full FIFO is
// accepted when a pop happens in the same cycle, so a streaming consumer
// never costs a dropped byte.
module tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty = (count_r == CW'(0));
  assign full  = (count_r == CW'(DEPTH));
  assign count = count_r;
  // Head reads as zero when nothing is queued so a reset FIFO shows 0
  assign data  = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);

  // Storage, pointers and occupancy; reset discards anything queued
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/memory_bus_responder.sv
// Single-cycle CPU data-bus responder: word RAM, GPIO register, 64-bit cycle
// counter with a coherent high-word snapshot, TX byte FIFO and a sticky
// unmapped-access flag. Loads are combinational from the address.
module memory_bus_responder
  import memory_map::*;
#(
  parameter int          RAM_WORDS         = 256,
  parameter int          TX_DEPTH          = 4,
  // Counter value loaded on reset; zero in normal use
  parameter logic [63:0] CYCLE_RESET_VALUE = 64'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        write_enable,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic [31:0] gpio_out,
  output logic        bus_error
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int TX_CW  = $clog2(TX_DEPTH) + 1;

  logic [31:0]      ram_r [RAM_WORDS];
  logic [63:0]      cycle_r;
  logic [31:0]      snapshot_r;
  logic [31:0]      gpio_r;
  logic             overflow_r;
  logic             bus_error_r;

  logic [29:0]      word_addr_s;
  logic             ram_hit_s;
  region_e          region_s;
  logic [RAM_AW-1:0] ram_idx_s;
  logic             tx_push_s;
  logic             tx_pop_s;
  logic             tx_drop_s;
  logic             status_clear_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [TX_CW-1:0] fifo_count_s;
  logic [2:0]       count3_s;
  logic [31:0]      status_s;

  assign word_addr_s = address[31:2];
  assign ram_hit_s   = ((word_addr_s >> RAM_AW) == 30'd0);
  assign region_s    = decode_region(word_addr_s, ram_hit_s);
  assign ram_idx_s   = word_addr_s[RAM_AW-1:0];

  assign tx_valid       = !fifo_empty_s;
  assign tx_pop_s       = tx_valid && tx_ready;
  assign tx_push_s      = write_enable && (region_s == REGION_TX_DATA);
  assign tx_drop_s      = tx_push_s && fifo_full_s && !tx_pop_s;
  assign status_clear_s = write_enable && (region_s == REGION_TX_STATUS)
                          && write_data[STAT_OVERFLOW_BIT];

  assign count3_s = 3'(fifo_count_s);

  // Assemble TX_STATUS from the package bit positions
  always_comb begin
    status_s = 32'd0;
    status_s[STAT_FULL_BIT]                    = fifo_full_s;
    status_s[STAT_EMPTY_BIT]                   = fifo_empty_s;
    status_s[STAT_COUNT_MSB:STAT_COUNT_LSB]    = count3_s;
    status_s[STAT_OVERFLOW_BIT]                = overflow_r;
  end

  tx_fifo #(
    .DEPTH (TX_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (tx_push_s),
    .pop       (tx_pop_s),
    .push_data (write_data[7:0]),
    .data      (tx_data),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  // Zero-latency load mux; unmapped and write-only locations read as zero
  always_comb begin
    case (region_s)
      REGION_RAM:       read_data = ram_r[ram_idx_s];
      REGION_GPIO:      read_data = gpio_r;
      REGION_CYCLE_LO:  read_data = cycle_r[31:0];
      REGION_CYCLE_HI:  read_data = snapshot_r;
      REGION_TX_STATUS: read_data = status_s;
      default:          read_data = 32'd0;
    endcase
  end

  // Data RAM store port; contents deliberately survive reset
  always_ff @(posedge clock) begin
    if (write_enable && (region_s == REGION_RAM)) begin
      ram_r[ram_idx_s] <= write_data;
    end
  end

  // Counter, high-word snapshot, GPIO, overflow and bus-error state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_r     <= CYCLE_RESET_VALUE;
      snapshot_r  <= 32'd0;
      gpio_r      <= 32'd0;
      overflow_r  <= 1'b0;
      bus_error_r <= 1'b0;
    end else begin
      cycle_r <= cycle_r + 64'd1;
      // Reading the low word freezes the high word so a LO-then-HI pair is coherent
      if ((region_s == REGION_CYCLE_LO) && !write_enable) begin
        snapshot_r <= cycle_r[63:32];
      end
      if (write_enable && (region_s == REGION_GPIO)) begin
        gpio_r <= write_data;
      end
      // A drop in the same cycle as a clear keeps the flag set
      if (tx_drop_s) begin
        overflow_r <= 1'b1;
      end else if (status_clear_s) begin
        overflow_r <= 1'b0;
      end
      if (region_s == REGION_UNMAPPED) begin
        bus_error_r <= 1'b1;
      end
    end
  end

  assign gpio_out  = gpio_r;
  assign bus_error = bus_error_r;

endmodule
